keypad_scan_encoder: RTL and testbench

//  Input-side counterpart of the multiplexed seven-segment display driver: scans a 4x4 matrix keypad
//  by driving one-cold rows and reading the active-low columns. It debounces key presses and encodes

---
 rtl/keypad_scan_encoder.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// rtl/keypad_scan_encoder.sv - 4x4 matrix keypad scanner, debouncer and hex nibble shift register
//
// Ports:
//   clk       in   system clock, all state on posedge
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous clear of value
//   col_n     in   [3:0] keypad columns, active-low, asynchronous to clk
//   row_n     out  [3:0] one-cold row drive, bit r low = row r driven
//   key_code  out  [3:0] code of the last accepted key
//   key_valid out  one-cycle pulse per accepted key
//   value     out  [15:0] last four accepted codes, newest in [3:0]
module keypad_scan_encoder #(
    parameter int SCAN_DIV_BITS   = 15,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] value
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD
    } state_e;

    // Frame accumulator classification: nothing seen, one key seen, more than one key seen
    localparam logic [1:0] HITS_NONE   = 2'd0;
    localparam logic [1:0] HITS_SINGLE = 2'd1;
    localparam logic [1:0] HITS_MULTI  = 2'd2;

    logic [3:0]               col_s1_q, col_s2_q;
    logic [SCAN_DIV_BITS-1:0] div_q;
    logic [1:0]               row_idx_q;
    logic [1:0]               hits_q;
    logic [3:0]               code_q;
    state_e                   state_q, state_d;
    logic [3:0]               cand_q, cand_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            rel_q, rel_d;
    logic                     key_valid_q;
    logic [3:0]               key_code_q;
    logic [15:0]              value_q;

    logic       tick;
    logic       frame_end;
    logic [3:0] col_low;
    logic [2:0] row_hits;
    logic [1:0] col_idx;
    logic [1:0] hits_m;
    logic [3:0] code_m;
    logic       accept;

    assign tick      = &div_q;
    assign frame_end = tick && (row_idx_q == 2'd3);

    // Merge the current row's sample into the running frame classification.
    // The merged result is what the FSM sees on the frame-end tick, so row 3
    // counts toward the frame it belongs to.
    always_comb begin
        col_low  = ~col_s2_q;
        row_hits = {2'b00, col_low[0]} + {2'b00, col_low[1]}
                 + {2'b00, col_low[2]} + {2'b00, col_low[3]};
        col_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (col_low[i]) col_idx = 2'(i);
        end
        hits_m = hits_q;
        code_m = code_q;
        if (row_hits == 3'd1) begin
            if (hits_q == HITS_NONE) begin
                hits_m = HITS_SINGLE;
                code_m = {row_idx_q, col_idx};
            end else begin
                hits_m = HITS_MULTI;
            end
        end else if (row_hits >= 3'd2) begin
            hits_m = HITS_MULTI;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (hits_m == HITS_SINGLE) begin
                        state_d = ST_DEBOUNCE;
                        cand_d  = code_m;
                        cnt_d   = CW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (hits_m == HITS_SINGLE) begin
                        if (code_m == cand_q) begin
                            if (cnt_q + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
                                accept  = 1'b1;
                                rel_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_HELD;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end else begin
                            cand_d = code_m;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    // Only a run of empty frames re-arms; a held key never repeats
                    if (hits_m == HITS_NONE) begin
                        if (rel_q + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
                            state_d = ST_IDLE;
                            rel_d   = '0;
                        end else begin
                            rel_d = rel_q + CW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q    <= 4'b1111;
            col_s2_q    <= 4'b1111;
            div_q       <= '0;
            row_idx_q   <= 2'd0;
            hits_q      <= HITS_NONE;
            code_q      <= 4'd0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            rel_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            value_q     <= 16'h0000;
        end else begin
            col_s1_q    <= col_n;
            col_s2_q    <= col_s1_q;
            div_q       <= div_q + SCAN_DIV_BITS'(1);
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_valid_q <= accept;
            if (tick) begin
                row_idx_q <= row_idx_q + 2'd1;
                if (frame_end) begin
                    hits_q <= HITS_NONE;
                    code_q <= 4'd0;
                end else begin
                    hits_q <= hits_m;
                    code_q <= code_m;
                end
            end
            if (accept) begin
                key_code_q <= cand_q;
            end
            // clear takes priority over a coincident accept
            if (clear) begin
                value_q <= 16'h0000;
            end else if (accept) begin
                value_q <= {value_q[11:0], cand_q};
            end
        end
    end

    assign row_n     = ~(4'b0001 << row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign value     = value_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb/tb_keypad_scan_encoder.sv - self-checking bench for keypad_scan_encoder
module tb_keypad_scan_encoder;

    localparam int SDB   = 2;
    localparam int DF    = 3;
    localparam int FRAME = 4 * (1 << SDB);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] value;

    logic [15:0] keys;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    bit          m_armed;
    int          m_streak;
    int          m_scode;
    int          m_none;
    logic [3:0]  m_code;
    logic [15:0] m_value;

    typedef struct {
        logic [15:0] m;
        int          n;
    } step_t;

    keypad_scan_encoder #(
        .SCAN_DIV_BITS  (SDB),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .value    (value)
    );

    always #5 clk = ~clk;

    // Keypad: each pressed switch shorts its row to its column
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
    end

    function automatic int popc(input logic [15:0] m);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic int first_bit(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_armed  = 1'b1;
        m_streak = 0;
        m_scode  = 0;
        m_none   = 0;
        m_code   = 4'h0;
        m_value  = 16'h0000;
    endtask

    // Frame-level model: a key is accepted when DF consecutive frames show the same
    // lone key while armed; after an accept, DF consecutive empty frames re-arm.
    task automatic model_frame(input logic [15:0] m, input bit clr, output bit acc);
        int n = popc(m);
        acc = 1'b0;
        if (m_armed) begin
            if (n == 1) begin
                if (m_streak > 0 && first_bit(m) == m_scode) m_streak++;
                else begin m_streak = 1; m_scode = first_bit(m); end
                if (m_streak == DF) begin
                    acc = 1'b1; m_armed = 1'b0; m_none = 0; m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (n == 0) begin
                m_none++;
                if (m_none == DF) begin m_armed = 1'b1; m_streak = 0; end
            end else begin
                m_none = 0;
            end
        end
        if (acc) m_code = 4'(m_scode);
        if (clr) m_value = 16'h0000;
        else if (acc) m_value = {m_value[11:0], 4'(m_scode)};
    endtask

    // Drives one scan frame with a fixed key set; optionally pulses clear on the frame-end cycle
    task automatic run_frame(input logic [15:0] m, input bit clr_last,
                             output int pulses, output bit pulse_end, output int row_bad);
        logic [3:0] er;
        keys      = m;
        pulses    = 0;
        pulse_end = 1'b0;
        row_bad   = 0;
        for (int k = 1; k <= FRAME; k++) begin
            if (k == FRAME && clr_last) clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            cyc++;
            er = ~(4'b0001 << ((cyc / (1 << SDB)) % 4));
            if (row_n !== er) row_bad++;
            if (key_valid === 1'b1) begin
                pulses++;
                if (k == FRAME) pulse_end = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        keys  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        model_reset();
    endtask

    task automatic test_reset();
        int p, rb; bit pe, acc; int total = 0;
        rst_n = 1'b0; clear = 1'b0; keys = 16'h0000;
        #1;
        checks++;
        if (row_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || value !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: got row_n=%b kv=%b code=%h value=%h want 1110 0 0 0000",
                     row_n, key_valid, key_code, value);
        end
        apply_reset();
        for (int f = 0; f < 20; f++) begin
            run_frame(16'h0000, 1'b0, p, pe, rb);
            model_frame(16'h0000, 1'b0, acc);
            total += p;
            checks++;
            if (rb != 0 || p != 0 || value !== 16'h0000) begin
                fails++;
                $display("FAIL idle_scan frame %0d: got row_errs=%0d pulses=%0d value=%h want 0 0 0000",
                         f, rb, p, value);
            end
        end
    endtask

    task automatic test_single_key();
        step_t seq[4] = '{'{16'h0200, 10}, '{16'h0000, 5}, '{16'h0200, 10}, '{16'h0000, 5}};
        int p, rb; bit pe, acc; int total = 0;
        foreach (seq[i]) begin
            for (int f = 0; f < seq[i].n; f++) begin
                run_frame(seq[i].m, 1'b0, p, pe, rb);
                model_frame(seq[i].m, 1'b0, acc);
                total += p;
                checks++;
                if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                    fails++;
                    $display("FAIL single_key step %0d frame %0d: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                             i, f, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
                end
            end
        end
        checks++;
        if (total != 2 || key_code !== 4'h9 || value !== 16'h0099) begin
            fails++;
            $display("FAIL single_key_total: got pulses=%0d code=%h value=%h want 2 9 0099", total, key_code, value);
        end
    endtask

    task automatic test_sequence();
        int p, rb; bit pe, acc; int total = 0;
        logic [15:0] m;
        for (int k = 1; k <= 5; k++) begin
            for (int f = 0; f < 10; f++) begin
                m = (f < 5) ? (16'h0001 << k) : 16'h0000;
                run_frame(m, 1'b0, p, pe, rb);
                model_frame(m, 1'b0, acc);
                total += p;
                checks++;
                if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                    fails++;
                    $display("FAIL sequence key %0d frame %0d: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                             k, f, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
                end
            end
            if (k == 4) begin
                checks++;
                if (value !== 16'h1234) begin
                    fails++;
                    $display("FAIL sequence_1234: got value=%h want 1234", value);
                end
            end
        end
        checks++;
        if (total != 5 || value !== 16'h2345) begin
            fails++;
            $display("FAIL sequence_total: got pulses=%0d value=%h want 5 2345", total, value);
        end
    endtask

    task automatic test_multi_key();
        step_t seq[4] = '{'{16'h8001, 8}, '{16'h0000, 3}, '{16'h00C0, 8}, '{16'h0000, 5}};
        int p, rb; bit pe, acc; int total = 0;
        logic [15:0] v0 = value;
        foreach (seq[i]) begin
            for (int f = 0; f < seq[i].n; f++) begin
                run_frame(seq[i].m, 1'b0, p, pe, rb);
                model_frame(seq[i].m, 1'b0, acc);
                total += p;
                checks++;
                if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                    fails++;
                    $display("FAIL multi_key step %0d frame %0d: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                             i, f, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
                end
            end
        end
        checks++;
        if (total != 0 || value !== v0) begin
            fails++;
            $display("FAIL multi_key_total: got pulses=%0d value=%h want 0 %h", total, value, v0);
        end
    endtask

    task automatic test_bounce();
        step_t seq[7] = '{'{16'h0008, 1}, '{16'h0000, 1}, '{16'h0008, 2}, '{16'h0000, 1},
                          '{16'h0008, 3}, '{16'h0000, 5}, '{16'h0000, 0}};
        int p, rb; bit pe, acc; int bounce_pulses = 0; int total = 0;
        foreach (seq[i]) begin
            for (int f = 0; f < seq[i].n; f++) begin
                run_frame(seq[i].m, 1'b0, p, pe, rb);
                model_frame(seq[i].m, 1'b0, acc);
                total += p;
                if (i < 4) bounce_pulses += p;
                checks++;
                if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                    fails++;
                    $display("FAIL bounce step %0d frame %0d: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                             i, f, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
                end
            end
        end
        checks++;
        if (bounce_pulses != 0 || total != 1 || key_code !== 4'h3) begin
            fails++;
            $display("FAIL bounce_total: got bounce_pulses=%0d pulses=%0d code=%h want 0 1 3",
                     bounce_pulses, total, key_code);
        end
    endtask

    task automatic test_reset_mid_and_clear();
        int p, rb; bit pe, acc; int fpulses = 0;
        for (int f = 0; f < 2; f++) begin
            run_frame(16'h0020, 1'b0, p, pe, rb);
            model_frame(16'h0020, 1'b0, acc);
            checks++;
            if (p != int'(acc) || key_code !== m_code || value !== m_value) begin
                fails++;
                $display("FAIL pre_reset frame %0d: got pulses=%0d code=%h value=%h want %0d %h %h",
                         f, p, key_code, value, int'(acc), m_code, m_value);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (row_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || value !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_state: got row_n=%b kv=%b code=%h value=%h want 1110 0 0 0000",
                     row_n, key_valid, key_code, value);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b0 || value !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_hold: got kv=%b value=%h want 0 0000", key_valid, value);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        model_reset();
        for (int f = 0; f < 14; f++) begin
            logic [15:0] m;
            bit clr;
            m   = (f < 3) ? 16'h0020 : (f >= 8 && f < 11) ? 16'h8000 : 16'h0000;
            clr = (f == 10);
            run_frame(m, clr, p, pe, rb);
            model_frame(m, clr, acc);
            if (f >= 8) fpulses += p;
            checks++;
            if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                fails++;
                $display("FAIL post_reset frame %0d: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                         f, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
            end
            if (f == 2) begin
                checks++;
                if (p != 1 || key_code !== 4'h5 || value !== 16'h0005) begin
                    fails++;
                    $display("FAIL held_through_reset: got pulses=%0d code=%h value=%h want 1 5 0005", p, key_code, value);
                end
            end
        end
        checks++;
        if (fpulses != 1 || key_code !== 4'hF || value !== 16'h0000) begin
            fails++;
            $display("FAIL clear_on_accept: got pulses=%0d code=%h value=%h want 1 f 0000", fpulses, key_code, value);
        end
    endtask

    task automatic test_random();
        int p, rb; bit pe, acc, clr;
        logic [15:0] m = 16'h0000;
        int hold = 0;
        int a, b, sel;
        for (int f = 0; f < 80; f++) begin
            if (hold == 0) begin
                sel  = $urandom_range(99);
                a    = $urandom_range(15);
                b    = (a + 1 + $urandom_range(14)) % 16;
                if (sel < 40)      m = 16'h0000;
                else if (sel < 85) m = 16'h0001 << a;
                else               m = (16'h0001 << a) | (16'h0001 << b);
                hold = 1 + $urandom_range(5);
            end
            hold--;
            clr = ($urandom_range(15) == 0);
            run_frame(m, clr, p, pe, rb);
            model_frame(m, clr, acc);
            checks++;
            if (p != int'(acc) || pe !== acc || key_code !== m_code || value !== m_value || rb != 0) begin
                fails++;
                $display("FAIL random frame %0d keys=%h: got pulses=%0d end=%b code=%h value=%h row_errs=%0d want %0d %b %h %h 0",
                         f, m, p, pe, key_code, value, rb, int'(acc), acc, m_code, m_value);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_multi_key();
        test_bounce();
        test_reset_mid_and_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
